alu_mdu: RTL
============

Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle execute ALU.
- Adds shifts, compares, 32-bit word mode, and an iterative multiply/divide/remainder path.
- Uses valid/ready handshakes on both sides.
- Sits in the execute stage; one operation in flight; decode supplies operands and opcode, memory stage consumes the result.

Parameters:
- WIDTH, 64, datapath width in bits (32 or 64).
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of in-flight/held op
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit can accept
- op  in  5  operation code (below)
- word  in  1  32-bit word mode (ignored when WIDTH=32)
- a, b  in  WIDTH  operands
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  result

Behaviour:
- Opcodes:
  - 0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU
  - 11 MUL (low WIDTH bits), 12 DIV, 13 DIVU, 14 REM, 15 REMU
  - others produce 0 with normal latency.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating; in_ready=0.
  - DONE: out_valid=1.
  - in_ready = IDLE, or (DONE and out_ready): back-to-back issue allowed.
- Accept happens on in_valid&&in_ready. Operands and op are captured into internal registers; inputs are don't-care afterwards.
- Ops 0-10: result registered; DONE the cycle after accept (latency 1).
- Ops 11-15:
  - BUSY for N iterations, N = 32 in word mode, else WIDTH.
  - Then DONE. Latency N+1 cycles from accept to out_valid.
  - MUL: shift-add, one bit per cycle.
  - DIV/REM: restoring shift-subtract on magnitudes; signs are fixed up in the final cycle.
- DONE → IDLE on out_ready with no new accept. If a new accept occurs in that same cycle, go to BUSY or DONE per the new op. out_data is stable while out_valid && !out_ready.
- Shifts: amount is b[SHW-1:0], or b[4:0] in word mode.
- SLT/SLTU: result is 1 or 0, zero-extended.
- Word mode, WIDTH=64:
  - Operate on a[31:0], b[31:0].
  - Signed ops sign-extend the operands from bit 31; unsigned ops zero-extend them.
  - Result is sign-extended from bit 31 for every op.
  - SRL/SRA shift the 32-bit value.
- Divide by zero (checked at accept, still takes N+1 cycles):
  - DIV/DIVU: quotient = all ones.
  - REM/REMU: remainder = dividend.
- Signed overflow (most-negative ÷ −1): quotient = dividend, remainder = 0.
- Remainder takes the sign of the dividend; quotient truncates toward zero.
- flush:
  - Highest priority over everything, including in_valid.
  - Next cycle: IDLE, out_valid=0.
  - No accept occurs in a flush cycle.
- Reset (resetn low, async): state IDLE, out_valid=0, out_data=0, all iteration registers 0. in_ready is 1 while in reset. Reset mid-BUSY abandons the op with no output.

Test Plan:
- WIDTH=64: ADD a=5, b=7 accepted cycle 0 → out_valid cycle 1, out_data=12. SUB 3−5 → 0xFFFF_FFFF_FFFF_FFFE. PASS_B b=0xABC → 0xABC.
- SRA a=0x8000_0000_0000_0000, b=0x43 → shift 3 → 0xF000_0000_0000_0000. SLL word a=1, b=31 → 0xFFFF_FFFF_8000_0000.
- MUL a=−3, b=7: out_valid exactly 65 cycles after accept, out_data=−21. Word MUL 0x10000×0x10000 → 0 after 33 cycles.
- Divide boundaries, WIDTH=64:
  - DIV −7/2 → −3; REM −7/2 → −1.
  - DIVU 10/0 → all ones; REM 10/0 → 10.
  - DIV 0x8000_0000_0000_0000/−1 → 0x8000_0000_0000_0000; REM same operands → 0.
- Back-pressure: hold out_ready=0 for 5 cycles after DONE → out_data stable, in_ready=0. Then assert out_ready with in_valid ADD 1+1 → next cycle out_data=2, no bubble.
- Assert flush mid-DIV (cycle 10): next cycle IDLE, no out_valid, in_ready=1. Pulse resetn low mid-MUL: outputs immediately 0, then a new ADD completes normally.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with iterative multiply/divide and valid/ready on both sides.
// One op in flight; word mode (WIDTH=64) works on the low 32 bits and sign-extends the result.
module alu_mdu #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic             word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic             wm_q, wm_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, res_q, res_d;

    logic             wm, sgn, is_md, is_rem, accept, ge;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] ea, eb, mag_a, mag_b, alu_r, x_n, y_n, acc_n, q_fix, r_fix, md_r;
    logic [WIDTH:0]   rs, diff;

    function automatic logic [WIDTH-1:0] sx32(input logic [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] t;
        t = v << (WIDTH - 32);
        return t >>> (WIDTH - 32);
    endfunction

    function automatic logic [WIDTH-1:0] zx32(input logic [WIDTH-1:0] v);
        return (v << (WIDTH - 32)) >> (WIDTH - 32);
    endfunction

    assign wm     = (WIDTH == 64) && word;
    assign sgn    = op == 5'd8 || op == 5'd9 || op == 5'd12 || op == 5'd14;
    assign is_md  = op >= 5'd11 && op <= 5'd15;
    assign ea     = wm ? (sgn ? sx32(a) : zx32(a)) : a;
    assign eb     = wm ? (sgn ? sx32(b) : zx32(b)) : b;
    assign sh     = wm ? SHW'(b[4:0]) : b[SHW-1:0];
    assign mag_a  = (sgn && ea[WIDTH-1]) ? -ea : ea;
    assign mag_b  = (sgn && eb[WIDTH-1]) ? -eb : eb;
    assign in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = state_q == DONE;
    assign out_data  = res_q;

    always_comb begin
        case (op)
            5'd0:    alu_r = eb;
            5'd1:    alu_r = ea + eb;
            5'd2:    alu_r = ea - eb;
            5'd3:    alu_r = ea & eb;
            5'd4:    alu_r = ea | eb;
            5'd5:    alu_r = ea ^ eb;
            5'd6:    alu_r = ea << sh;
            5'd7:    alu_r = ea >> sh;
            5'd8:    alu_r = $signed(ea) >>> sh;
            5'd9:    alu_r = WIDTH'($signed(ea) < $signed(eb));
            5'd10:   alu_r = WIDTH'(ea < eb);
            default: alu_r = '0;
        endcase
    end

    // MUL: shift-add into acc; DIV/REM: restoring divide, x holds dividend/quotient, acc the remainder.
    assign rs     = {acc_q, x_q[WIDTH-1]};
    assign diff   = rs - {1'b0, y_q};
    assign ge     = !diff[WIDTH];
    assign acc_n  = op_q == 5'd11 ? acc_q + (y_q[0] ? x_q : '0) : ge ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
    assign x_n    = op_q == 5'd11 ? x_q << 1 : {x_q[WIDTH-2:0], ge};
    assign y_n    = op_q == 5'd11 ? y_q >> 1 : y_q;
    assign q_fix  = negq_q ? -x_n : x_n;
    assign r_fix  = negr_q ? -acc_n : acc_n;
    assign is_rem = op_q == 5'd14 || op_q == 5'd15;
    assign md_r   = op_q == 5'd11 ? acc_n : is_rem ? r_fix : dz_q ? '1 : q_fix;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wm_d    = wm_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            op_d    = op;
            wm_d    = wm;
            // word-mode dividend is pre-aligned to the top so 32 steps consume all its bits
            x_d     = op == 5'd11 ? ea : wm ? mag_a << 32 : mag_a;
            y_d     = op == 5'd11 ? eb : mag_b;
            acc_d   = '0;
            cnt_d   = wm ? CW'(32) : CW'(WIDTH);
            negq_d  = sgn && (ea[WIDTH-1] ^ eb[WIDTH-1]);
            negr_d  = sgn && ea[WIDTH-1];
            dz_d    = eb == '0;
            state_d = is_md ? BUSY : DONE;
            res_d   = is_md ? res_q : (wm ? sx32(alu_r) : alu_r);
        end else if (state_q == BUSY) begin
            x_d   = x_n;
            y_d   = y_n;
            acc_d = acc_n;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                res_d   = wm_q ? sx32(md_r) : md_r;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= '0;
            wm_q    <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wm_q    <= wm_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end
endmodule
